// File: rtl/med_pkg.sv
// Shared types and sizing helpers for the median sequencer.
// State encoding, pass count and counter widths derived from SIZE.
package med_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SORT = 2'd2,
        HOLD = 2'd3
    } state_e;

    function automatic int passes(input int size);
        return (size + 1) / 2;
    endfunction

    function automatic int cnt_w(input int size);
        return $clog2(size);
    endfunction

    function automatic int pass_w(input int size);
        return $clog2(passes(size) + 1);
    endfunction

    localparam int PASSES = passes(9);

endpackage

// File: rtl/med_ctrl_if.sv
// Valid/ready sample stream used on both sides of med_ctrl.
// Ports: data, valid (source to sink), ready (sink to source).
interface med_ctrl_if #(parameter int N = 7);

    logic [N:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/MED.sv
// 9-tap median datapath: SIZE-entry register ring with sort network.
// Ports: CLK, DI sample in, DSI shift-in, BYP bypass/sort select, DO median tap.
module MED #(
    parameter int N    = 7,
    parameter int SIZE = 9
) (
    input  logic       CLK,
    input  logic [N:0] DI,
    input  logic       DSI,
    input  logic       BYP,
    output logic [N:0] DO
);

    logic [N:0] r [SIZE];
    logic [N:0] s [SIZE];
    logic [N:0] t;

    // One odd-even transposition round (two layers) per compare cycle;
    // larger values move toward the top index.
    always_comb begin
        s = r;
        t = '0;
        for (int i = 0; i + 1 < SIZE; i += 2) begin
            if (s[i] > s[i+1]) begin
                t      = s[i];
                s[i]   = s[i+1];
                s[i+1] = t;
            end
        end
        for (int i = 1; i + 1 < SIZE; i += 2) begin
            if (s[i] > s[i+1]) begin
                t      = s[i];
                s[i]   = s[i+1];
                s[i+1] = t;
            end
        end
    end

    // Bypass without DSI leaves the ring untouched, so stall cycles
    // never push a loaded sample out of the window.
    always_ff @(posedge CLK) begin
        if (!BYP) begin
            r <= s;
        end else if (DSI) begin
            r[0] <= DI;
            for (int i = 1; i < SIZE; i++)
                r[i] <= r[i-1];
        end
    end

    assign DO = r[SIZE/2];

endmodule

// File: rtl/med_ctrl.sv
// Median sequencer: loads SIZE samples, runs sort passes, holds result.
// Ports: CLK, RST_N, in_s (sample stream), out_m (median stream), BUSY.
module med_ctrl
    import med_pkg::*;
#(
    parameter int N    = 7,
    parameter int SIZE = 9
) (
    input  logic       CLK,
    input  logic       RST_N,
    med_ctrl_if.slave  in_s,
    med_ctrl_if.master out_m,
    output logic       BUSY
);

    localparam int NP = passes(SIZE);
    localparam int CW = cnt_w(SIZE);
    localparam int PW = pass_w(SIZE);

    localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);
    localparam logic [PW-1:0] PAS_LAST = PW'(NP - 1);

    state_e        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] pas;
    logic [N:0]    odata;
    logic [N:0]    dout;
    logic          dsi;
    logic          byp;
    logic          acc;

    assign in_s.ready  = (state == IDLE) || (state == LOAD);
    assign out_m.valid = (state == HOLD);
    assign out_m.data  = odata;
    assign BUSY        = (state != IDLE);

    assign acc = in_s.valid & in_s.ready;
    assign dsi = acc;
    // Compare/exchange on every sort cycle except the pass-closing one.
    assign byp = !((state == SORT) && (cnt != CNT_LAST));

    MED #(.N(N), .SIZE(SIZE)) u_med (
        .CLK (CLK),
        .DI  (in_s.data),
        .DSI (dsi),
        .BYP (byp),
        .DO  (dout)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            pas   <= '0;
            odata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc) begin
                        cnt   <= CW'(1);
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (acc) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            pas   <= '0;
                            state <= SORT;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                SORT: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (pas == PAS_LAST) begin
                            pas   <= '0;
                            odata <= dout;
                            state <= HOLD;
                        end else begin
                            pas <= pas + PW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (out_m.ready)
                        state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_med_ctrl.sv
// Self-checking bench for med_ctrl: table vectors, corner sequences,
// and random windows against a sort-based median model.
module tb_med_ctrl;

    localparam int N  = 7;
    localparam int SZ = 9;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    med_ctrl_if #(.N(N)) up();
    med_ctrl_if #(.N(N)) dn();

    med_ctrl #(.N(N), .SIZE(SZ)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .in_s  (up),
        .out_m (dn),
        .BUSY  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int xfer_cnt = 0;
    int rdy_viol = 0;

    always @(posedge clk) begin
        if (up.valid && up.ready) acc_cnt++;
        if (dn.valid && dn.ready) xfer_cnt++;
    end

    typedef struct {
        logic [71:0] w;
        logic [7:0]  med;
        int          mode;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [71:0] pk(input int a0, a1, a2, a3, a4,
                                       a5, a6, a7, a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4),
                8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // Reference: median is the middle element of the sorted window.
    function automatic logic [7:0] gold(input logic [71:0] w);
        int q[$];
        for (int i = 0; i < SZ; i++) q.push_back(int'(w[i*8 +: 8]));
        q.sort();
        return 8'(q[SZ/2]);
    endfunction

    // mode 0: back-to-back, 1: valid toggles 1/0, 2: random gaps
    task automatic send_win(input logic [71:0] w, input int mode);
        int gap;
        for (int i = 0; i < SZ; i++) begin
            if (mode == 1 && i > 0) gap = 1;
            else if (mode == 2) gap = int'($urandom_range(0, 2));
            else gap = 0;
            for (int g = 0; g < gap; g++) begin
                if (!up.ready) rdy_viol++;
                up.valid = 1'b0;
                up.data  = 8'($urandom);
                @(posedge clk); #1;
            end
            if (!up.ready) rdy_viol++;
            up.data  = w[i*8 +: 8];
            up.valid = 1'b1;
            @(posedge clk); #1;
        end
        up.valid = 1'b0;
    endtask

    task automatic wait_out(output logic [7:0] d, output int lat);
        lat = 1;
        while (!dn.valid && lat < 200) begin
            if (up.ready) rdy_viol++;
            @(posedge clk); #1;
            lat++;
        end
        d = dn.data;
        if (!dn.valid) chk("out_valid timeout", 32'(dn.valid), 32'd1);
    endtask

    task automatic finish_xfer();
        chk("hold in_ready", 32'(up.ready), 32'd0);
        @(posedge clk); #1;
        chk("valid drop", 32'(dn.valid), 32'd0);
        chk("idle in_ready", 32'(up.ready), 32'd1);
        chk("idle busy", 32'(busy), 32'd0);
    endtask

    logic [7:0]  d;
    logic [7:0]  held;
    logic [71:0] w;
    int          lat;
    int          a0;
    int          x0;
    int          viol;

    initial begin
        up.valid = 1'b0;
        up.data  = '0;
        dn.ready = 1'b1;
        rst_n    = 1'b0;

        vecs[0] = '{pk(1, 2, 3, 4, 5, 6, 7, 8, 9), 8'd5, 0};
        vecs[1] = '{pk(9, 8, 7, 6, 5, 4, 3, 2, 1), 8'd5, 0};
        vecs[2] = '{pk(200, 3, 200, 3, 200, 3, 200, 3, 3), 8'd3, 0};
        vecs[3] = '{pk(255, 255, 255, 255, 255, 255, 255, 255, 255),
                    8'hFF, 0};
        vecs[4] = '{pk(4, 4, 9, 1, 7, 2, 8, 3, 6), 8'd4, 1};

        #12;
        chk("rst in_ready", 32'(up.ready), 32'd1);
        chk("rst out_valid", 32'(dn.valid), 32'd0);
        chk("rst out_data", 32'(dn.data), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            a0 = acc_cnt;
            x0 = xfer_cnt;
            rdy_viol = 0;
            send_win(vecs[v].w, vecs[v].mode);
            chk("accepts", 32'(acc_cnt - a0), 32'd9);
            chk("busy sort", 32'(busy), 32'd1);
            wait_out(d, lat);
            chk("median", 32'(d), 32'(vecs[v].med));
            chk("model", 32'(d), 32'(gold(vecs[v].w)));
            if (v == 0) chk("latency", 32'(lat), 32'd46);
            finish_xfer();
            chk("xfers", 32'(xfer_cnt - x0), 32'd1);
            chk("ready viol", 32'(rdy_viol), 32'd0);
        end

        // Downstream stalls for 20 cycles in HOLD.
        dn.ready = 1'b0;
        x0 = xfer_cnt;
        w = pk(10, 90, 20, 80, 30, 70, 40, 60, 50);
        send_win(w, 0);
        wait_out(d, lat);
        chk("hold median", 32'(d), 32'd50);
        held = d;
        viol = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (!dn.valid || dn.data !== held || up.ready) viol++;
        end
        chk("hold stable", 32'(viol), 32'd0);
        chk("hold no xfer", 32'(xfer_cnt - x0), 32'd0);
        dn.ready = 1'b1;
        @(posedge clk); #1;
        chk("hold release valid", 32'(dn.valid), 32'd0);
        chk("hold release ready", 32'(up.ready), 32'd1);
        chk("hold one xfer", 32'(xfer_cnt - x0), 32'd1);

        // Reset during the second sort pass.
        w = pk(5, 1, 4, 2, 3, 9, 8, 7, 6);
        send_win(w, 0);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid rst ready", 32'(up.ready), 32'd1);
        chk("mid rst valid", 32'(dn.valid), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst data", 32'(dn.data), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        x0 = xfer_cnt;
        viol = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (dn.valid) viol++;
        end
        chk("no stale valid", 32'(viol), 32'd0);
        chk("no stale xfer", 32'(xfer_cnt - x0), 32'd0);
        w = pk(33, 11, 77, 22, 66, 44, 99, 55, 88);
        send_win(w, 0);
        wait_out(d, lat);
        chk("post rst median", 32'(d), 32'(gold(w)));
        finish_xfer();

        // Random back-to-back windows with random input gaps.
        x0 = xfer_cnt;
        rdy_viol = 0;
        for (int it = 0; it < 1000; it++) begin
            for (int i = 0; i < SZ; i++)
                w[i*8 +: 8] = (it % 2 == 0) ? 8'($urandom)
                                            : 8'($urandom_range(0, 7));
            send_win(w, 2);
            wait_out(d, lat);
            chk("rand median", 32'(d), 32'(gold(w)));
            finish_xfer();
        end
        chk("rand xfers", 32'(xfer_cnt - x0), 32'd1000);
        chk("rand ready viol", 32'(rdy_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
